vga_pattern_gen: RTL and testbench
==================================

// Module: vga_pattern_gen
// PURPOSE
// Parametrised VGA timing plus test-pattern generator. It replaces the fixed
// divide-by-4, single-colour display test. Timing, pixel-clock divide, lane
// count and colour depth are parameters. A 2-bit mode selects one of four
// patterns, including a lane view used to bring up the 4K-mania playfield.
// PARAMETERS
// H_ACTIVE 640 visible pixels/line (multiple of 8 and of LANES)
// H_FP 16 / H_SYNC 96 / H_BP 48   horizontal porch/sync widths, pixels
// V_ACTIVE 480 visible lines/frame
// V_FP 10 / V_SYNC 2 / V_BP 33    vertical porch/sync widths, lines
// CLK_DIV 4   clk cycles per pixel (>=1)
// LANES 4     lane count for mode 2 (>=1)
// CW 4        bits per colour channel; colour word is 3*CW, {r,g,b}
// PORTS
// clk        in  1     system clock
// rst        in  1     synchronous reset, active-low
// mode       in  2     0 solid, 1 colour bars, 2 lanes, 3 scrolling checker
// fg_color   in  3*CW  foreground colour {r,g,b}
// lane_hit   in  LANES lane i lit in mode 2
// hs, vs     out 1     syncs, active-low
// r, g, b    out CW    pixel colour, zero outside active area
// col        out 10    current h counter (pre-register), 0..H_TOTAL-1
// row        out 10    current v counter (pre-register), 0..V_TOTAL-1
// active     out 1     registered visible-area flag, aligned with r/g/b
// frame_start out 1    one-clk pulse at each frame boundary
// BEHAVIOUR
// - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
// - pe (pixel enable): div counter 0..CLK_DIV-1; pe=1 when cnt==CLK_DIV-1.
// - On pe: h+=1, wrapping H_TOTAL-1->0. v+=1 on h wrap, wrapping V_TOTAL-1->0.
// - hs_n=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vs_n uses the same
//   rule on v with V_* values.
// - vis = (h<H_ACTIVE)&&(v<V_ACTIVE).
// - hs, vs, active, r, g, b: registered on pe from the current h/v.
//   Latency is 1 pixel (CLK_DIV clocks), equal for all of them.
// - Frame boundary: pe && h==H_TOTAL-1 && v==V_TOTAL-1. frame_start=1 for
//   that clk only. On the same edge: mode_q<=mode, lane_q<=lane_hit, scroll+=1.
//   scroll is 10 bits and wraps. mode/lane_hit changes mid-frame take effect
//   at the next frame.
// - Pixel colour when vis=1 (col=h, row=v):
//   * mode 0: fg_color.
//   * mode 1: 8 bars, bar=h/(H_ACTIVE/8). Colours white, yellow, cyan, green,
//     magenta, red, blue, black. Each channel is all-ones or zero.
//   * mode 2: LW=H_ACTIVE/LANES, lane=h/LW. If (h mod LW)<2: all-ones
//     (separator). Else if lane_q[lane]: fg_color. Else each channel of
//     fg_color shifted right by 1 (dim).
//   * mode 3: ((h+scroll)[5] ^ v[5]) ? fg_color : 0. Sum is 10-bit, wraps.
// - Colour when vis=0: 0.
// - Reset (rst=0 at a clk edge): div cnt, h, v, scroll, mode_q, lane_q = 0.
//   Outputs: hs=1, vs=1, r=g=b=0, active=0, frame_start=0.
//   Reset mid-frame restarts timing at h=v=0. First pe comes CLK_DIV clocks
//   after rst rises.
// TESTING
// - Reset: rst=0 for 3 clk -> hs=vs=1, rgb=0, active=0, col=row=0.
//   Release: first col increment is 4 clk later.
// - Line timing, defaults: hs low 384 clk every 3200 clk.
//   vs low 2 lines (6400 clk) every 525 lines. frame_start period 1,680,000 clk.
// - Mode 1: pixel 0 -> FFF. Pixel 80 -> FF0. Pixel 639 -> 000.
//   Pixel 640 -> 000 with active=0.
// - Mode 2, fg=0x8C4, lane_hit=4'b0010: px 0-1 -> FFF. px 2 -> 462.
//   px 162 -> 8C4. px 320 -> FFF.
// - Mode switched 0->1 at line 100: the rest of that frame stays solid.
//   Bars start after the next frame_start.
// - rst pulsed low at h=300, v=200: next visible pixel outputs match h=0, v=0.
//   hs/vs are held high during reset.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing generator with four selectable
// test patterns (solid, colour bars, lane view, scrolling checker).
// Timing counters run on a divided pixel enable. Sync, visible flag and
// colour are registered together, so they share one pixel of latency.
// Pattern mode and lane mask are latched only at the frame boundary.
module vga_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int LANES    = 4,
    parameter int CW       = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [1:0]          i_mode,
    input  logic [3*CW-1:0]     i_fg_color,
    input  logic [LANES-1:0]    i_lane_hit,
    output logic                o_hs,
    output logic                o_vs,
    output logic [CW-1:0]       o_r,
    output logic [CW-1:0]       o_g,
    output logic [CW-1:0]       o_b,
    output logic [9:0]          o_col,
    output logic [9:0]          o_row,
    output logic                o_active,
    output logic                o_frame_start
);

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_LANES   = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_e;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LIDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int LANE_W  = H_ACTIVE / LANES;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAR_LAST   = 10'(BAR_W - 1);
    localparam logic [9:0] LANE_LAST  = 10'(LANE_W - 1);
    localparam logic [CW-1:0] ONES    = {CW{1'b1}};

    logic [DIV_W-1:0]  r_divCnt;
    logic [9:0]        r_hCount;
    logic [9:0]        r_vCount;
    logic [9:0]        r_barPos;
    logic [2:0]        r_barIdx;
    logic [9:0]        r_lanePos;
    logic [LIDX_W-1:0] r_laneIdx;
    mode_e             r_modeQ;
    logic [LANES-1:0]  r_laneQ;
    logic [9:0]        r_scroll;
    logic              r_hs;
    logic              r_vs;
    logic              r_active;
    logic [3*CW-1:0]   r_rgb;

    logic              w_pe;
    logic              w_hLast;
    logic              w_vLast;
    logic              w_frameEdge;
    logic              w_vis;
    logic              w_hsN;
    logic              w_vsN;
    logic [9:0]        w_scrolled;
    logic [CW-1:0]     w_fgR;
    logic [CW-1:0]     w_fgG;
    logic [CW-1:0]     w_fgB;
    logic [3*CW-1:0]   w_dim;
    logic [3*CW-1:0]   w_colour;
    logic [3*CW-1:0]   w_pixel;

    assign w_pe        = (r_divCnt == DIV_LAST);
    assign w_hLast     = (r_hCount == H_LAST);
    assign w_vLast     = (r_vCount == V_LAST);
    assign w_frameEdge = w_pe & w_hLast & w_vLast;
    assign w_vis       = (r_hCount < H_ACT) && (r_vCount < V_ACT);
    assign w_hsN       = !((r_hCount >= HS_START) && (r_hCount < HS_END));
    assign w_vsN       = !((r_vCount >= VS_START) && (r_vCount < VS_END));
    assign w_scrolled  = r_hCount + r_scroll;
    assign w_fgR       = i_fg_color[3*CW-1:2*CW];
    assign w_fgG       = i_fg_color[2*CW-1:CW];
    assign w_fgB       = i_fg_color[CW-1:0];
    assign w_dim       = {w_fgR >> 1, w_fgG >> 1, w_fgB >> 1};

    // Clock divider producing a one-clk pixel enable every CLK_DIV clocks.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_divCnt <= '0;
        end else if (w_pe) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    // Horizontal and vertical raster counters, advanced once per pixel.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hCount <= '0;
            r_vCount <= '0;
        end else if (w_pe) begin
            if (w_hLast) begin
                r_hCount <= '0;
                r_vCount <= w_vLast ? 10'd0 : r_vCount + 10'd1;
            end else begin
                r_hCount <= r_hCount + 10'd1;
            end
        end
    end

    // Bar and lane position trackers avoid dividing h by a non-power-of-two;
    // they freeze past the visible area and restart when the line wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_barPos  <= '0;
            r_barIdx  <= '0;
            r_lanePos <= '0;
            r_laneIdx <= '0;
        end else if (w_pe) begin
            if (w_hLast) begin
                r_barPos  <= '0;
                r_barIdx  <= '0;
                r_lanePos <= '0;
                r_laneIdx <= '0;
            end else if (r_hCount < H_ACT_LAST) begin
                if (r_barPos == BAR_LAST) begin
                    r_barPos <= '0;
                    r_barIdx <= r_barIdx + 3'd1;
                end else begin
                    r_barPos <= r_barPos + 10'd1;
                end
                if (r_lanePos == LANE_LAST) begin
                    r_lanePos <= '0;
                    r_laneIdx <= r_laneIdx + 1'b1;
                end else begin
                    r_lanePos <= r_lanePos + 10'd1;
                end
            end
        end
    end

    // Frame-boundary latch: mode and lane mask only change between frames.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_modeQ  <= MODE_SOLID;
            r_laneQ  <= '0;
            r_scroll <= '0;
        end else if (w_frameEdge) begin
            r_modeQ  <= mode_e'(i_mode);
            r_laneQ  <= i_lane_hit;
            r_scroll <= r_scroll + 10'd1;
        end
    end

    // Pattern colour for the current raster position, blanked outside vis.
    always_comb begin
        w_colour = '0;
        case (r_modeQ)
            MODE_SOLID: begin
                w_colour = i_fg_color;
            end
            MODE_BARS: begin
                w_colour = {{CW{~r_barIdx[1]}}, {CW{~r_barIdx[2]}}, {CW{~r_barIdx[0]}}};
            end
            MODE_LANES: begin
                if (r_lanePos < 10'd2) begin
                    w_colour = {ONES, ONES, ONES};
                end else if (r_laneQ[r_laneIdx]) begin
                    w_colour = i_fg_color;
                end else begin
                    w_colour = w_dim;
                end
            end
            MODE_CHECKER: begin
                w_colour = (w_scrolled[5] ^ r_vCount[5]) ? i_fg_color : '0;
            end
            default: begin
                w_colour = '0;
            end
        endcase
        w_pixel = w_vis ? w_colour : '0;
    end

    // Registered video outputs, all captured on the same pixel enable.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_active <= 1'b0;
            r_rgb    <= '0;
        end else if (w_pe) begin
            r_hs     <= w_hsN;
            r_vs     <= w_vsN;
            r_active <= w_vis;
            r_rgb    <= w_pixel;
        end
    end

    assign o_hs          = r_hs;
    assign o_vs          = r_vs;
    assign o_active      = r_active;
    assign o_r           = r_rgb[3*CW-1:2*CW];
    assign o_g           = r_rgb[2*CW-1:CW];
    assign o_b           = r_rgb[CW-1:0];
    assign o_col         = r_hCount;
    assign o_row         = r_vCount;
    assign o_frame_start = w_frameEdge & i_rst;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: self-checking bench for vga_pattern_gen.
// Horizontal timing and clock divide use the defaults; the vertical
// timing is shortened so several whole frames fit in a short run.
module tb_vga_pattern_gen;

   localparam int H_ACTIVE  = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_ACTIVE  = 3;
   localparam int V_FP      = 1;
   localparam int V_SYNC    = 1;
   localparam int V_BP      = 1;
   localparam int CLK_DIV   = 4;
   localparam int LANES     = 4;
   localparam int CW        = 4;
   localparam int HT        = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT        = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FRAME_PIX = HT * VT;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    mode;
   logic [11:0]   fg;
   logic [3:0]    laneHit;
   logic          hs, vs, active, frameStart;
   logic [3:0]    r, g, b;
   logic [9:0]    col, row;
   logic [11:0]   rgb;

   assign rgb = {r, g, b};

   vga_pattern_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .CLK_DIV(CLK_DIV), .LANES(LANES), .CW(CW)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_mode(mode),
      .i_fg_color(fg),
      .i_lane_hit(laneHit),
      .o_hs(hs),
      .o_vs(vs),
      .o_r(r),
      .o_g(g),
      .o_b(b),
      .o_col(col),
      .o_row(row),
      .o_active(active),
      .o_frame_start(frameStart)
   );

   always #5 clk = ~clk;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model state: mN counts clocks since reset release.
   int            mN = 0;
   bit            mValid = 1'b0;
   int            mModeQ = 0;
   logic [3:0]    mLaneQ = '0;
   int            mScroll = 0;
   logic          eHs = 1'b1;
   logic          eVs = 1'b1;
   logic          eActive = 1'b0;
   logic [11:0]   eRgb = '0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Pattern colour derived directly from the pattern rules.
   function automatic logic [11:0] modelColour(input int h, input int v, input int md,
                                               input logic [3:0] lanes, input int scroll,
                                               input logic [11:0] fgc);
      logic [11:0] barTable [8];
      logic [3:0]  cr, cg, cb;
      int          lw;
      barTable = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
      lw = H_ACTIVE / LANES;
      cr = fgc[11:8];
      cg = fgc[7:4];
      cb = fgc[3:0];
      if (h >= H_ACTIVE || v >= V_ACTIVE) return 12'h000;
      case (md)
         0: return fgc;
         1: return barTable[h / (H_ACTIVE / 8)];
         2: begin
            if ((h % lw) < 2) return 12'hFFF;
            else if (lanes[h / lw]) return fgc;
            else return {4'(cr / 2), 4'(cg / 2), 4'(cb / 2)};
         end
         default: return ((((h + scroll) % 1024) / 32) % 2 != (v / 32) % 2) ? fgc : 12'h000;
      endcase
   endfunction

   // Model advance: position from elapsed clocks, outputs for the pixel just finished.
   always @(posedge clk) begin : modelStep
      int pix, cnt, h, v;
      if (rst === 1'b0) begin
         mN = 0; mModeQ = 0; mLaneQ = '0; mScroll = 0;
         eHs = 1'b1; eVs = 1'b1; eActive = 1'b0; eRgb = '0;
         mValid = 1'b1;
      end else if (mValid) begin
         cnt = mN % CLK_DIV;
         pix = mN / CLK_DIV;
         h = pix % HT;
         v = (pix / HT) % VT;
         if (cnt == CLK_DIV - 1) begin
            eHs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
            eVs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
            eActive = (h < H_ACTIVE) && (v < V_ACTIVE);
            eRgb = modelColour(h, v, mModeQ, mLaneQ, mScroll, fg);
            if (h == HT - 1 && v == VT - 1) begin
               mModeQ = int'(mode);
               mLaneQ = laneHit;
               mScroll = (mScroll + 1) % 1024;
            end
         end
         mN++;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin : compareStep
      int pix, h, v;
      logic eFs;
      if (mValid) begin
         pix = mN / CLK_DIV;
         h = pix % HT;
         v = (pix / HT) % VT;
         eFs = (mN % CLK_DIV == CLK_DIV - 1) && (h == HT - 1) && (v == VT - 1) && (rst === 1'b1);
         checkOutput("hs", hs, eHs);
         checkOutput("vs", vs, eVs);
         checkOutput("active", active, eActive);
         checkOutput("rgb", rgb, eRgb);
         checkOutput("col", col, h);
         checkOutput("row", row, v);
         checkOutput("frame_start", frameStart, eFs);
      end
   end

   // Sync and frame-pulse run-length monitor.
   int clkCount = 0;
   int hsRun = 0, hsLowLen = 0, hsFallT = -1, hsPeriod = 0;
   int vsRun = 0, vsLowLen = 0, vsFallT = -1, vsPeriod = 0;
   int fsRun = 0, fsWidth = 0, fsRiseT = -1, fsPeriod = 0;
   logic prevHs = 1'b1, prevVs = 1'b1, prevFs = 1'b0;

   always @(negedge clk) begin
      clkCount++;
      if (hs === 1'b0) hsRun++;
      else begin if (hsRun > 0) hsLowLen = hsRun; hsRun = 0; end
      if (prevHs === 1'b1 && hs === 1'b0) begin
         if (hsFallT >= 0) hsPeriod = clkCount - hsFallT;
         hsFallT = clkCount;
      end
      if (vs === 1'b0) vsRun++;
      else begin if (vsRun > 0) vsLowLen = vsRun; vsRun = 0; end
      if (prevVs === 1'b1 && vs === 1'b0) begin
         if (vsFallT >= 0) vsPeriod = clkCount - vsFallT;
         vsFallT = clkCount;
      end
      if (frameStart === 1'b1) fsRun++;
      else begin if (fsRun > 0) fsWidth = fsRun; fsRun = 0; end
      if (prevFs === 1'b0 && frameStart === 1'b1) begin
         if (fsRiseT >= 0) fsPeriod = clkCount - fsRiseT;
         fsRiseT = clkCount;
      end
      prevHs = hs;
      prevVs = vs;
      prevFs = frameStart;
   end

   task automatic stepClk();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic rstVal, input logic [1:0] modeVal,
                                input logic [11:0] fgVal, input logic [3:0] laneVal);
      rst = rstVal;
      mode = modeVal;
      fg = fgVal;
      laneHit = laneVal;
   endtask

   // Waits until the outputs show pixel (h,v) of frame f since the last reset.
   task automatic waitForPixel(input int f, input int h, input int v);
      int target;
      int budget;
      target = f * FRAME_PIX + v * HT + h + 1;
      budget = 0;
      while ((mN / CLK_DIV) != target && budget < 40000) begin
         @(negedge clk);
         budget++;
      end
      if ((mN / CLK_DIV) != target) checkOutput("waitForPixel timeout", mN / CLK_DIV, target);
   endtask

   initial begin
      int edges;
      applyStimulus(1'b0, 2'd0, 12'h8C4, 4'b0010);
      repeat (3) stepClk();
      checkOutput("reset hs", hs, 1);
      checkOutput("reset vs", vs, 1);
      checkOutput("reset rgb", rgb, 0);
      checkOutput("reset active", active, 0);
      checkOutput("reset col", col, 0);
      checkOutput("reset row", row, 0);

      applyStimulus(1'b1, 2'd0, 12'h8C4, 4'b0010);
      edges = 0;
      while (col == 10'd0 && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
      checkOutput("first col step clocks", edges, 4);

      waitForPixel(0, 0, 1);
      stepClk();
      applyStimulus(1'b1, 2'd1, 12'h8C4, 4'b0010);
      waitForPixel(0, 5, 2);
      checkOutput("solid after mid-frame switch", rgb, 12'h8C4);

      waitForPixel(1, 0, 0);
      checkOutput("bars px0", rgb, 12'hFFF);
      waitForPixel(1, 80, 0);
      checkOutput("bars px80", rgb, 12'hFF0);
      waitForPixel(1, 639, 0);
      checkOutput("bars px639", rgb, 12'h000);
      checkOutput("bars px639 active", active, 1);
      waitForPixel(1, 640, 0);
      checkOutput("bars px640", rgb, 12'h000);
      checkOutput("bars px640 active", active, 0);
      stepClk();
      applyStimulus(1'b1, 2'd2, 12'h8C4, 4'b0010);

      waitForPixel(2, 0, 0);
      checkOutput("lanes px0", rgb, 12'hFFF);
      waitForPixel(2, 1, 0);
      checkOutput("lanes px1", rgb, 12'hFFF);
      waitForPixel(2, 2, 0);
      checkOutput("lanes px2", rgb, 12'h462);
      waitForPixel(2, 162, 0);
      checkOutput("lanes px162", rgb, 12'h8C4);
      waitForPixel(2, 320, 0);
      checkOutput("lanes px320", rgb, 12'hFFF);
      stepClk();
      applyStimulus(1'b1, 2'd3, 12'h8C4, 4'b0010);

      waitForPixel(3, 0, 0);
      checkOutput("checker px0", rgb, 12'h000);
      checkOutput("checker px0 active", active, 1);
      waitForPixel(3, 28, 0);
      checkOutput("checker px28", rgb, 12'h000);
      waitForPixel(3, 29, 0);
      checkOutput("checker px29", rgb, 12'h8C4);

      checkOutput("hs low clocks", hsLowLen, 384);
      checkOutput("hs period clocks", hsPeriod, 3200);
      checkOutput("vs low clocks", vsLowLen, 3200);
      checkOutput("vs period clocks", vsPeriod, 19200);
      checkOutput("frame_start width", fsWidth, 1);
      checkOutput("frame_start period", fsPeriod, 19200);

      waitForPixel(3, 299, 1);
      stepClk();
      applyStimulus(1'b0, 2'd3, 12'h8C4, 4'b0010);
      repeat (3) stepClk();
      checkOutput("mid reset hs", hs, 1);
      checkOutput("mid reset vs", vs, 1);
      checkOutput("mid reset col", col, 0);
      checkOutput("mid reset row", row, 0);
      checkOutput("mid reset rgb", rgb, 0);
      applyStimulus(1'b1, 2'd3, 12'h8C4, 4'b0010);
      waitForPixel(0, 0, 0);
      checkOutput("post reset px0 rgb", rgb, 12'h8C4);
      checkOutput("post reset px0 active", active, 1);
      waitForPixel(0, 40, 0);
      checkOutput("post reset px40 rgb", rgb, 12'h8C4);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
